// File: rtl/ds_pkt_sender_if.sv
`default_nettype none
// ============================================================================
// Module  : ds_pkt_sender_if
// Brief   : NAP data-stream TX bundle (valid/ready/sop/eop/addr/data).
// Revision: 1.0 - initial release
// ============================================================================
interface ds_pkt_sender_if #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 4
);
    logic                  valid;
    logic                  ready;
    logic                  sop;
    logic                  eop;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, sop, eop, addr, data, input ready);
    modport slave  (input valid, sop, eop, addr, data, output ready);
endinterface
`default_nettype wire

// File: rtl/ds_pkt_sender.sv
`default_nettype none
// ============================================================================
// Module  : ds_pkt_sender
// Brief   : Periodic multi-beat packet generator on a NAP data-stream TX port,
//           rotating round-robin through a destination table and stamping
//           beat/sequence/destination numbers into every beat.
// Revision: 1.0 - initial release
// ============================================================================
module ds_pkt_sender #(
    parameter int DATA_WIDTH   = 256,
    parameter int ADDR_WIDTH   = 4,
    parameter int NUM_DEST     = 4,
    parameter int BEAT_WIDTH   = 8,
    parameter int PERIOD_WIDTH = 24
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           enable,
    input  logic [PERIOD_WIDTH-1:0]        period,
    input  logic [BEAT_WIDTH-1:0]          pkt_beats,
    input  logic [$clog2(NUM_DEST):0]      num_active,
    input  logic [NUM_DEST*ADDR_WIDTH-1:0] dest_table,
    ds_pkt_sender_if.master                tx,
    output logic [31:0]                    pkt_count,
    output logic                           busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    localparam int REPS = (DATA_WIDTH + 31) / 32;

    // Beat layout: {replicated low word..., 12'b0, dest index, seq, beat index}
    function automatic logic [DATA_WIDTH-1:0] make_beat(
        input logic [15:0] beat_idx,
        input logic [15:0] seq,
        input logic [3:0]  idx
    );
        logic [31:0]          word;
        logic [REPS*32+47:0]  full;
        word = {seq, beat_idx};
        full = {{REPS{word}}, 12'd0, idx, word};
        return full[DATA_WIDTH-1:0];
    endfunction

    logic [1:0]              r_state;
    logic [PERIOD_WIDTH-1:0] r_cnt;
    logic [PERIOD_WIDTH-1:0] r_period;
    logic [BEAT_WIDTH-1:0]   r_beat;
    logic [BEAT_WIDTH-1:0]   r_last;
    logic [4:0]              r_n;
    logic [3:0]              r_idx;
    logic [15:0]             r_seq;

    logic [4:0]              w_n;
    logic [BEAT_WIDTH-1:0]   w_last;
    logic                    w_eop_xfer;
    logic                    w_start;
    logic [15:0]             w_seq_base;
    logic [3:0]              w_idx_base;
    logic [3:0]              w_start_idx;
    logic [ADDR_WIDTH-1:0]   w_addr;

    // Packet-start parameters and the seq/index a starting packet will carry
    // (already advanced when the start coincides with the previous eop).
    always_comb begin
        w_n = 5'(NUM_DEST);
        if (num_active != '0 && 5'(num_active) <= 5'(NUM_DEST))
            w_n = 5'(num_active);
        w_last      = (pkt_beats == '0) ? '0 : pkt_beats - BEAT_WIDTH'(1);
        w_eop_xfer  = (r_state == ST_SEND) && tx.valid && tx.ready && (r_beat == r_last);
        w_seq_base  = w_eop_xfer ? r_seq + 16'd1 : r_seq;
        w_idx_base  = r_idx;
        if (w_eop_xfer)
            w_idx_base = ((5'(r_idx) + 5'd1) >= r_n) ? 4'd0 : r_idx + 4'd1;
        w_start_idx = (5'(w_idx_base) >= w_n) ? 4'd0 : w_idx_base;
        w_addr      = '0;
        for (int i = 0; i < NUM_DEST; i++) begin
            if (w_start_idx == 4'(i))
                w_addr = dest_table[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
        w_start = 1'b0;
        case (r_state)
            ST_IDLE: w_start = enable && (period == '0);
            ST_WAIT: w_start = enable && (r_cnt == '0);
            ST_SEND: w_start = w_eop_xfer && enable && (r_period == '0);
            default: w_start = 1'b0;
        endcase
    end

    // Sequencer: gap counting, beat stepping, packet bookkeeping, packet start.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_period  <= '0;
            r_beat    <= '0;
            r_last    <= '0;
            r_n       <= 5'(NUM_DEST);
            r_idx     <= '0;
            r_seq     <= '0;
            pkt_count <= '0;
            busy      <= 1'b0;
            tx.valid  <= 1'b0;
            tx.sop    <= 1'b0;
            tx.eop    <= 1'b0;
            tx.addr   <= '0;
            tx.data   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable && period != '0) begin
                        r_state <= ST_WAIT;
                        r_cnt   <= period - PERIOD_WIDTH'(1);
                        busy    <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (!enable) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - PERIOD_WIDTH'(1);
                    end
                end
                ST_SEND: begin
                    if (w_eop_xfer) begin
                        tx.valid  <= 1'b0;
                        tx.sop    <= 1'b0;
                        tx.eop    <= 1'b0;
                        pkt_count <= pkt_count + 32'd1;
                        r_seq     <= w_seq_base;
                        r_idx     <= w_idx_base;
                        if (!enable) begin
                            r_state <= ST_IDLE;
                            busy    <= 1'b0;
                        end else if (r_period != '0) begin
                            r_state <= ST_WAIT;
                            r_cnt   <= r_period - PERIOD_WIDTH'(1);
                        end
                    end else if (tx.valid && tx.ready) begin
                        r_beat  <= r_beat + BEAT_WIDTH'(1);
                        tx.sop  <= 1'b0;
                        tx.eop  <= ((r_beat + BEAT_WIDTH'(1)) == r_last);
                        tx.data <= make_beat(16'(r_beat + BEAT_WIDTH'(1)), r_seq, r_idx);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase

            if (w_start) begin
                r_state  <= ST_SEND;
                r_period <= period;
                r_beat   <= '0;
                r_last   <= w_last;
                r_n      <= w_n;
                r_idx    <= w_start_idx;
                busy     <= 1'b1;
                tx.valid <= 1'b1;
                tx.sop   <= 1'b1;
                tx.eop   <= (w_last == '0);
                tx.addr  <= w_addr;
                tx.data  <= make_beat(16'd0, w_seq_base, w_start_idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ds_pkt_sender.sv
`default_nettype none
// ============================================================================
// Module  : tb_ds_pkt_sender
// Brief   : Self-checking bench for ds_pkt_sender with a packet-level
//           timing/content reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ds_pkt_sender;

    localparam int DW = 256;
    localparam int AW = 4;
    localparam int ND = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          enable;
    logic [23:0]   period;
    logic [7:0]    pkt_beats;
    logic [2:0]    num_active;
    logic [ND*AW-1:0] dest_table;
    logic [31:0]   pkt_count;
    logic          busy;

    ds_pkt_sender_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) tx ();

    ds_pkt_sender #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_DEST(ND), .BEAT_WIDTH(8), .PERIOD_WIDTH(24)
    ) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .period(period),
        .pkt_beats(pkt_beats), .num_active(num_active), .dest_table(dest_table),
        .tx(tx), .pkt_count(pkt_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: packet in flight / waiting for a sop at a known cycle.
    bit          m_in_pkt, m_wait;
    int          m_sop_at, m_beat, m_L, m_N, m_idx, m_per;
    logic [15:0] m_seq;
    logic [31:0] m_pkts;
    logic [3:0]  m_addr;

    function automatic logic [DW-1:0] exp_data(input int beat, input logic [15:0] seq, input int idx);
        logic [31:0]   w;
        logic [3:0]    d;
        logic [DW-1:0] r;
        w = {seq, 16'(beat)};
        d = 4'(idx);
        for (int k = 0; k < DW; k++) begin
            if (k < 32)      r[k] = w[k];
            else if (k < 36) r[k] = d[k-32];
            else if (k < 48) r[k] = 1'b0;
            else             r[k] = w[(k-48) % 32];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_in_pkt = 0; m_wait = 0; m_seq = 0; m_idx = 0; m_pkts = 0;
        m_beat = 0; m_L = 1; m_N = ND; m_per = 0; m_addr = 0; m_sop_at = 0;
    endtask

    task automatic m_start();
        m_L = (pkt_beats == 0) ? 1 : int'(pkt_beats);
        m_N = (num_active == 0 || int'(num_active) > ND) ? ND : int'(num_active);
        if (m_idx >= m_N) m_idx = 0;
        m_addr   = dest_table[m_idx*AW +: AW];
        m_per    = int'(period);
        m_beat   = 0;
        m_in_pkt = 1;
        m_wait   = 0;
    endtask

    task automatic m_update(input bit xfer);
        if (xfer) begin
            if (m_beat == m_L - 1) begin
                m_in_pkt = 0;
                m_pkts++;
                m_seq++;
                m_idx = (m_idx + 1) % m_N;
                if (enable) begin m_wait = 1; m_sop_at = cyc + 1 + m_per; end
            end else begin
                m_beat++;
            end
        end else if (!m_in_pkt) begin
            if (!m_wait) begin
                if (enable) begin m_wait = 1; m_sop_at = cyc + 1 + int'(period); end
            end else if (!enable) begin
                m_wait = 0;
            end
        end
        if (m_wait && m_sop_at == cyc + 1) m_start();
    endtask

    // One clock: check this cycle's outputs, then advance the model.
    task automatic tick();
        bit xfer;
        @(negedge clk);
        chk("valid", DW'(tx.valid), DW'(m_in_pkt));
        chk("busy", DW'(busy), DW'(m_wait || m_in_pkt));
        chk("pkt_count", DW'(pkt_count), DW'(m_pkts));
        if (m_in_pkt) begin
            chk("sop", DW'(tx.sop), DW'(m_beat == 0));
            chk("eop", DW'(tx.eop), DW'(m_beat == m_L - 1));
            chk("addr", DW'(tx.addr), DW'(m_addr));
            chk("data", tx.data, exp_data(m_beat, m_seq, m_idx));
        end
        xfer = m_in_pkt && tx.ready;
        @(posedge clk);
        #1;
        if (resetn) m_update(xfer);
        cyc++;
    endtask

    task automatic wait_beat(input int b, input string tag);
        bit hit;
        hit = 0;
        for (int k = 0; k < 300; k++) begin
            if (m_in_pkt && m_beat == b) begin hit = 1; break; end
            tick();
        end
        chk(tag, DW'(hit), DW'(1));
    endtask

    task automatic run_until_idle(input string tag);
        bit hit;
        hit = 0;
        for (int k = 0; k < 300; k++) begin
            if (!m_in_pkt && !m_wait) begin hit = 1; break; end
            tick();
        end
        chk(tag, DW'(hit), DW'(1));
    endtask

    initial begin
        resetn = 1'b0; enable = 1'b0; period = 24'd3; pkt_beats = 8'd2;
        num_active = 3'd2; dest_table = '0; tx.ready = 1'b0;
        m_reset();
        for (int k = 0; k < 3; k++) tick();
        chk("rst_data", tx.data, '0);
        chk("rst_addr", DW'(tx.addr), '0);
        chk("rst_sop_eop", DW'({tx.sop, tx.eop}), '0);
        resetn = 1'b1;
        tick();

        // Test 1: period 3, two beats, two destinations {5,9}
        dest_table[0 +: 4] = 4'd5; dest_table[4 +: 4] = 4'd9;
        tx.ready = 1'b1; enable = 1'b1;
        for (int k = 0; k < 200 && m_pkts < 3; k++) tick();
        chk("t1_count", DW'(pkt_count), DW'(3));
        enable = 1'b0;
        run_until_idle("t1_idle");

        // Test 2: backpressure on beat 1 of a 4-beat packet
        pkt_beats = 8'd4; period = 24'd2; enable = 1'b1;
        wait_beat(1, "t2_reach_beat1");
        tx.ready = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        tx.ready = 1'b1;
        for (int k = 0; k < 4; k++) tick();

        // Test 3: back-to-back single-beat packets over four destinations
        dest_table = {4'd12, 4'd3, 4'd9, 4'd5};
        num_active = 3'd4; period = 24'd0; pkt_beats = 8'd0;
        for (int k = 0; k < 14; k++) tick();

        // Test 4: enable drop mid-packet completes the packet
        pkt_beats = 8'd8; period = 24'd1;
        wait_beat(2, "t4_reach_beat2");
        enable = 1'b0;
        run_until_idle("t4_idle");
        tick();
        chk("t4_busy", DW'(busy), '0);

        // Randomised configuration, backpressure and enable activity
        enable = 1'b1;
        for (int k = 0; k < 600; k++) begin
            if (k % 25 == 0) begin
                period     = 24'($urandom_range(0, 4));
                pkt_beats  = 8'($urandom_range(0, 5));
                num_active = 3'($urandom_range(0, 7));
                dest_table = 16'($urandom);
            end
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            tx.ready = ($urandom_range(0, 9) < 7);
            tick();
        end

        // Test 6: asynchronous reset mid-packet
        enable = 1'b1; tx.ready = 1'b1; period = 24'd1; pkt_beats = 8'd4;
        num_active = 3'd4;
        wait_beat(1, "t6_reach_beat1");
        #2;
        resetn = 1'b0;
        #1;
        chk("t6_valid", DW'(tx.valid), '0);
        chk("t6_count", DW'(pkt_count), '0);
        chk("t6_data", tx.data, '0);
        chk("t6_busy", DW'(busy), '0);
        m_reset();
        for (int k = 0; k < 2; k++) tick();
        resetn = 1'b1;
        for (int k = 0; k < 20; k++) tick();

        // Test 5: sequence-number wrap after 65536 single-beat packets
        resetn = 1'b0;
        m_reset();
        tick();
        resetn = 1'b1;
        period = 24'd0; pkt_beats = 8'd1; enable = 1'b1; tx.ready = 1'b1;
        for (int k = 0; k < 70000 && m_pkts < 32'd65537; k++) tick();
        chk("t5_count", DW'(pkt_count), DW'(65537));
        chk("t5_seq_now", DW'(tx.data[31:16]), DW'(16'h0001));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
